mem_port_arbiter: RTL and testbench

//  Shares the single 4-word-wide memory port between the instruction cache (I) and the data cache (D).

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle between the I/D caches, the arbiter
// and the memory model.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  localparam int LW = 4 * WORD_SIZE;

  logic          i_req;
  logic [15:0]   i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_done;

  logic          d_req;
  logic          d_we;
  logic [15:0]   d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_done;

  logic          readM;
  logic          writeM;
  logic [15:0]   address_memory;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic [15:0]   num_mem_access;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output i_rdata, i_done,
    output d_rdata, d_done,
    output readM, writeM,
    output address_memory, mem_wdata,
    output num_mem_access
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  i_rdata, i_done,
    input  d_rdata, d_done,
    input  readM, writeM,
    input  address_memory, mem_wdata,
    input  num_mem_access
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single line-wide memory port between I and D caches.
// Round-robin on ties, fixed MEM_LATENCY per line access.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int LW = 4 * WORD_SIZE;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [15:0]   addr_q, addr_d;
  logic [LW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] i_rdata_q, i_rdata_d;
  logic [LW-1:0] d_rdata_q, d_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   nacc_q, nacc_d;

  // owner/last: 1 = D side, 0 = I side
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_d     = cnt_q;
    nacc_d    = nacc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d = bus.d_req && (!bus.i_req || !last_q);
          we_d    = owner_d && bus.d_we;
          addr_d  = (owner_d ? bus.d_addr : bus.i_addr)
                    & 16'hFFFC;
          wdata_d = bus.d_wdata;
          last_d  = owner_d;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) d_rdata_d = bus.mem_rdata;
            else         i_rdata_d = bus.mem_rdata;
          end
        end
      end
      DONE: begin
        nacc_d  = nacc_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
      nacc_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
      nacc_q    <= nacc_d;
    end
  end

  logic busy;
  assign busy = (state_q == BUSY);

  assign bus.readM          = busy && !we_q;
  assign bus.writeM         = busy && we_q;
  assign bus.address_memory = busy ? addr_q : '0;
  assign bus.mem_wdata      = busy ? wdata_q : '0;
  assign bus.i_done         = (state_q == DONE) && !owner_q;
  assign bus.d_done         = (state_q == DONE) && owner_q;
  assign bus.i_rdata        = i_rdata_q;
  assign bus.d_rdata        = d_rdata_q;
  assign bus.num_mem_access = nacc_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level model
// predicts grants and timing, a negedge monitor checks the DUT.
module tb_mem_port_arbiter;
  localparam int L = 4;

  typedef struct {
    bit          owner;
    bit          we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          start;
  } exp_t;

  typedef struct {
    bit owner;
    int c;
  } log_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_seen;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus();

  mem_port_arbiter #(
    .WORD_SIZE(16),
    .MEM_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= reset;

  function automatic logic [63:0] memf(input logic [15:0] a);
    if (a == 16'h0010) return 64'h0123_4567_89AB_CDEF;
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1111};
  endfunction

  always_comb bus.mem_rdata = bus.readM ? memf(bus.address_memory)
                                        : 64'hFFFF_0000_FFFF_0000;

  exp_t q[$];
  log_t done_log[$];

  // model state of the requesters and the port
  bit          i_pend, d_pend, i_gnt, d_gnt;
  bit          i_keep, d_keep, last, d_w;
  int          i_dc, d_dc, free;
  logic [15:0] i_a, d_a;
  logic [63:0] d_wd;
  logic [15:0] exp_cnt;
  logic [63:0] exp_ir, exp_dr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_seen) begin
      chk("rst_readM", bus.readM, 0);
      chk("rst_writeM", bus.writeM, 0);
      chk("rst_done", {bus.i_done, bus.d_done}, 0);
      chk("rst_addr", bus.address_memory, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_ir", bus.i_rdata, 0);
      chk("rst_dr", bus.d_rdata, 0);
      chk("rst_cnt", bus.num_mem_access, 0);
      exp_cnt = '0;
      exp_ir  = '0;
      exp_dr  = '0;
    end else if (!reset) begin
      chk("strobe_excl", bus.readM && bus.writeM, 0);
      chk("done_excl", bus.i_done && bus.d_done, 0);
      chk("count", bus.num_mem_access, exp_cnt);
      if (bus.i_done || bus.d_done) begin
        if (q.size() == 0) begin
          chk("spurious_done", {bus.i_done, bus.d_done}, 0);
        end else begin
          e = q.pop_front();
          chk("done_owner", bus.d_done, e.owner);
          chk("done_cycle", cyc, e.start + L + 1);
          if (!e.we) begin
            if (e.owner) exp_dr = e.rdata;
            else         exp_ir = e.rdata;
          end
          exp_cnt = exp_cnt + 16'd1;
          done_log.push_back('{e.owner, cyc});
        end
      end else if (q.size() != 0 && cyc > q[0].start + L + 1) begin
        chk("done_timeout", 0, 1);
        void'(q.pop_front());
      end
      chk("i_rdata", bus.i_rdata, exp_ir);
      chk("d_rdata", bus.d_rdata, exp_dr);
      if (q.size() != 0 && cyc >= q[0].start + 1 &&
          cyc <= q[0].start + L) begin
        chk("readM", bus.readM, !q[0].we);
        chk("writeM", bus.writeM, q[0].we);
        chk("address", bus.address_memory, q[0].addr);
        if (q[0].we) chk("mem_wdata", bus.mem_wdata, q[0].wdata);
      end else begin
        chk("idle_strobes", {bus.readM, bus.writeM}, 0);
      end
    end
  end

  task automatic step(input bit rst, input bit gen, input bit pert);
    int   n;
    bit   own;
    exp_t e;
    @(posedge clk);
    #1;
    n = cyc;
    reset = rst;
    if (rst) begin
      q.delete();
      i_pend = 0; d_pend = 0; i_gnt = 0; d_gnt = 0;
      last = 0; free = 0;
      bus.i_req   = 1'($urandom);
      bus.i_addr  = 16'($urandom);
      bus.d_req   = 1'($urandom);
      bus.d_we    = 1'($urandom);
      bus.d_addr  = 16'($urandom);
      bus.d_wdata = {$urandom, $urandom};
      return;
    end
    if (i_gnt && n > i_dc) begin i_gnt = 0; i_pend = i_keep; end
    if (d_gnt && n > d_dc) begin d_gnt = 0; d_pend = d_keep; end
    if (gen && !i_pend && $urandom_range(3) == 0) begin
      i_pend = 1;
      i_a    = 16'($urandom);
    end
    if (gen && !d_pend && $urandom_range(3) == 0) begin
      d_pend = 1;
      d_w    = 1'($urandom);
      d_a    = 16'($urandom);
      d_wd   = {$urandom, $urandom};
    end
    if (i_gnt && pert) begin
      bus.i_req  = 0;
      bus.i_addr = 16'($urandom);
    end else begin
      bus.i_req  = i_pend;
      bus.i_addr = i_pend ? i_a : 16'($urandom);
    end
    if (d_gnt && pert) begin
      bus.d_req   = 0;
      bus.d_we    = 1'($urandom);
      bus.d_addr  = 16'($urandom);
      bus.d_wdata = {$urandom, $urandom};
    end else begin
      bus.d_req   = d_pend;
      bus.d_we    = d_pend ? d_w : 1'($urandom);
      bus.d_addr  = d_pend ? d_a : 16'($urandom);
      bus.d_wdata = d_pend ? d_wd : {$urandom, $urandom};
    end
    if (n >= free && (bus.i_req || bus.d_req)) begin
      own = (bus.i_req && bus.d_req) ? !last : bus.d_req;
      e.owner = own;
      e.we    = own && d_w;
      e.addr  = (own ? d_a : i_a) & 16'hFFFC;
      e.wdata = bus.d_wdata;
      e.rdata = memf(e.addr);
      e.start = n;
      q.push_back(e);
      if (own) begin d_gnt = 1; d_dc = n + L + 1; end
      else     begin i_gnt = 1; i_dc = n + L + 1; end
      free = n + L + 2;
      last = own;
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((i_pend || d_pend || q.size() != 0) && k < 80) begin
      step(0, 0, 0);
      k++;
    end
    chk(nm, k >= 80, 0);
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    i_keep = 0; d_keep = 0;

    step(1, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    chk("t1_idle_readM", bus.readM, 0);

    i_pend = 1; i_a = 16'h0013;
    drain("t2_drain");
    chk("t2_irdata", bus.i_rdata, 64'h0123_4567_89AB_CDEF);
    chk("t2_count", bus.num_mem_access, 1);

    step(1, 0, 0);
    step(1, 0, 0);
    done_log.delete();
    i_keep = 1; d_keep = 1;
    i_pend = 1; i_a = 16'h1234;
    d_pend = 1; d_w = 0; d_a = 16'h2345; d_wd = '0;
    for (int k = 0; k < 80 && done_log.size() < 4; k++)
      step(0, 0, 0);
    i_keep = 0; d_keep = 0;
    drain("t3_drain");
    if (done_log.size() < 4) begin
      chk("t3_ndone", done_log.size(), 4);
    end else begin
      chk("t3_g0", done_log[0].owner, 1);
      chk("t3_g1", done_log[1].owner, 0);
      chk("t3_g2", done_log[2].owner, 1);
      chk("t3_g3", done_log[3].owner, 0);
      for (int j = 1; j < 4; j++)
        chk("t3_space", done_log[j].c - done_log[j-1].c, L + 2);
    end

    d_pend = 1; d_w = 1; d_a = 16'h0FFE;
    d_wd = 64'hDEAD_BEEF_CAFE_F00D;
    drain("t4_drain");
    chk("t4_drdata", bus.d_rdata, exp_dr);

    i_pend = 1; i_a = 16'h0200;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    chk("t5_count", bus.num_mem_access, 0);
    d_pend = 1; d_w = 0; d_a = 16'h0444;
    drain("t5_drain");
    chk("t5_count2", bus.num_mem_access, 1);

    d_pend = 1; d_w = 0; d_a = 16'h3456;
    step(0, 0, 0);
    repeat (L + 3) step(0, 0, 1);
    drain("t6_drain");
    chk("t6_drdata", bus.d_rdata, memf(16'h3454));

    repeat (2000) begin
      if ($urandom_range(399) == 0) step(1, 0, 0);
      else                          step(0, 1, 1);
    end
    drain("rand_drain");
    repeat (2) step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
